// File: rtl/ext_mem_pkg.sv
// ext_mem_pkg: shared types and constants for the external memory arbiter
package ext_mem_pkg;
    typedef enum logic {IDLE, ACCESS} arb_state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [3:0] BE_WORD = 4'hF;
endpackage

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: arbitrates fetch and data requesters onto one external memory port
// Ports: clk, reset (sync, active-low); if_* fetch requester; dm_* data requester;
//        ext_* external memory port with ext_ready wait-state handshake; bus_err abort pulse.
// Optional: define EXT_MEM_ARBITER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without ext_ready.
// Data wins arbitration unless fetch has waited through FETCH_STARVE_LIMIT data grants.
module ext_mem_arbiter
    import ext_mem_pkg::*;
#(
    parameter int FETCH_STARVE_LIMIT = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_data_out,
    input  logic [31:0] ext_data_in,
    output logic        ext_mem_en,
    output logic        ext_we,
    output logic [3:0]  ext_be,
    input  logic        ext_ready,
    output logic        bus_err
);
    localparam int SW = $clog2(FETCH_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(FETCH_STARVE_LIMIT);
    arb_state_t state, state_nx;
    arb_owner_t owner;
    logic [SW-1:0] data_streak;
    logic fetch_win, done, abort;
    assign fetch_win = if_req && (!dm_req || data_streak == STREAK_MAX);
    assign if_gnt = reset && state == IDLE && fetch_win;
    assign dm_gnt = reset && state == IDLE && dm_req && !fetch_win;
    assign done = state == ACCESS && ext_ready;
`ifdef EXT_MEM_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    assign abort = state == ACCESS && !ext_ready && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        tmo_cnt <= (!reset || state != ACCESS) ? '0 : tmo_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
    assign abort = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? ((if_gnt || dm_gnt) ? ACCESS : IDLE)
                                   : ((done || abort) ? IDLE : ACCESS);
    end
    always_ff @(posedge clk) begin
        state <= !reset ? IDLE : state_nx;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner <= OWN_FETCH;
            data_streak <= '0;
            if_rvalid <= 1'b0;
            if_rdata <= '0;
            dm_rvalid <= 1'b0;
            dm_rdata <= '0;
            ext_addr <= '0;
            ext_data_out <= '0;
            ext_mem_en <= 1'b0;
            ext_we <= 1'b0;
            ext_be <= '0;
            bus_err <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            bus_err <= 1'b0;
            if (if_gnt || dm_gnt) begin
                owner <= if_gnt ? OWN_FETCH : OWN_DATA;
                ext_mem_en <= 1'b1;
                ext_addr <= (if_gnt ? if_addr : dm_addr) & 32'hFFFF_FFFC;
                ext_we <= dm_gnt && dm_we;
                ext_be <= if_gnt ? BE_WORD : dm_be;
                if (dm_gnt)
                    ext_data_out <= dm_wdata;
                data_streak <= if_gnt ? '0
                             : (if_req && data_streak != STREAK_MAX) ? data_streak + 1'b1
                             : data_streak;
            end
            if (done || abort) begin
                ext_mem_en <= 1'b0;
                ext_we <= 1'b0;
                ext_be <= '0;
                bus_err <= abort;
                if (owner == OWN_FETCH) begin
                    if_rvalid <= 1'b1;
                    if_rdata <= done ? ext_data_in : BUS_ERR_DATA;
                end else begin
                    dm_rvalid <= 1'b1;
                    if (!ext_we)
                        dm_rdata <= done ? ext_data_in : BUS_ERR_DATA;
                end
            end
        end
    end
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: directed self-checking bench for ext_mem_arbiter
module tb_ext_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [31:0] ext_addr;
    logic [31:0] ext_data_out;
    logic [31:0] ext_data_in;
    logic        ext_mem_en;
    logic        ext_we;
    logic [3:0]  ext_be;
    logic        ext_ready;
    logic        bus_err;
    int errors = 0;
    int checks = 0;

    ext_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ext_addr(ext_addr), .ext_data_out(ext_data_out), .ext_data_in(ext_data_in),
        .ext_mem_en(ext_mem_en), .ext_we(ext_we), .ext_be(ext_be),
        .ext_ready(ext_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [5:0] order;
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        ext_data_in = 32'h0; ext_ready = 1'b0;
        tick; tick;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_mem_en", ext_mem_en, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_dm_rvalid", dm_rvalid, 0);
        check("rst_ext_addr", ext_addr, 0);
        check("rst_ext_be", ext_be, 0);
        check("rst_bus_err", bus_err, 0);
        if_req = 1'b0;
        reset = 1'b1;
        tick;
        // fetch only, zero wait states
        if_req = 1'b1; if_addr = 32'h0000_0102; ext_ready = 1'b1; ext_data_in = 32'h0000_0013;
        #1;
        check("f_if_gnt", if_gnt, 1);
        check("f_dm_gnt", dm_gnt, 0);
        tick;
        if_req = 1'b0;
        check("f_mem_en", ext_mem_en, 1);
        check("f_ext_addr", ext_addr, 32'h0000_0100);
        check("f_ext_be", ext_be, 4'hF);
        check("f_ext_we", ext_we, 0);
        check("f_early_rvalid", if_rvalid, 0);
        tick;
        check("f_if_rvalid", if_rvalid, 1);
        check("f_if_rdata", if_rdata, 32'h0000_0013);
        check("f_mem_en_off", ext_mem_en, 0);
        tick;
        check("f_rvalid_pulse", if_rvalid, 0);
        // store with three wait states
        ext_ready = 1'b0; ext_data_in = 32'h0000_0055;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h3; dm_addr = 32'h20; dm_wdata = 32'hAABB_CCDD;
        #1;
        check("s_dm_gnt", dm_gnt, 1);
        tick;
        dm_req = 1'b0;
        check("s_ext_we", ext_we, 1);
        check("s_ext_be", ext_be, 4'h3);
        check("s_ext_addr", ext_addr, 32'h20);
        check("s_ext_dout", ext_data_out, 32'hAABB_CCDD);
        for (int i = 0; i < 4; i++) begin
            check("s_mem_en_hold", ext_mem_en, 1);
            check("s_no_rvalid", dm_rvalid, 0);
            check("s_we_hold", ext_we, 1);
            if (i == 3) ext_ready = 1'b1;
            tick;
        end
        check("s_dm_rvalid", dm_rvalid, 1);
        check("s_dm_rdata_kept", dm_rdata, 0);
        check("s_mem_en_off", ext_mem_en, 0);
        check("s_we_off", ext_we, 0);
        check("s_be_off", ext_be, 0);
        check("s_dout_hold", ext_data_out, 32'hAABB_CCDD);
        tick;
        check("s_rvalid_pulse", dm_rvalid, 0);
        // simultaneous requests, expect D D F D D F (bit=1 means fetch)
        order = 6'b100100;
        ext_ready = 1'b1;
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h800;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("c_if_gnt", if_gnt, order[i]);
            check("c_dm_gnt", dm_gnt, !order[i]);
            check("c_not_both", if_gnt & dm_gnt, 0);
            ext_data_in = 32'h100 + i;
            tick;
            check("c_mem_en", ext_mem_en, 1);
            check("c_ext_addr", ext_addr, order[i] ? 32'h400 : 32'h800);
            tick;
            check("c_if_rvalid", if_rvalid, order[i]);
            check("c_dm_rvalid", dm_rvalid, !order[i]);
            check("c_rdata", order[i] ? if_rdata : dm_rdata, 32'h100 + i);
            if (i == 5) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            #1;
        end
        tick;
        // reset during a wait-state access
        ext_ready = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        tick;
        dm_req = 1'b0;
        tick;
        check("r_mem_en_wait", ext_mem_en, 1);
        reset = 1'b0;
        ext_ready = 1'b1;
        tick;
        check("r_mem_en", ext_mem_en, 0);
        check("r_dm_rvalid", dm_rvalid, 0);
        check("r_dm_rdata", dm_rdata, 0);
        check("r_if_rdata", if_rdata, 0);
        check("r_ext_addr", ext_addr, 0);
        check("r_ext_dout", ext_data_out, 0);
        check("r_ext_be", ext_be, 0);
        reset = 1'b1;
        tick;
        check("r_no_late_rvalid", dm_rvalid, 0);
        check("r_idle", ext_mem_en, 0);
        if_req = 1'b1; if_addr = 32'h204; ext_data_in = 32'h77;
        #1;
        check("r_if_gnt", if_gnt, 1);
        tick;
        if_req = 1'b0;
        check("r_ext_addr2", ext_addr, 32'h204);
        tick;
        check("r_if_rvalid", if_rvalid, 1);
        check("r_if_rdata2", if_rdata, 32'h77);
        tick;
`ifdef EXT_MEM_ARBITER_TIMEOUT_EN
        // load that never completes: abort after 16 access cycles
        ext_ready = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        tick;
        dm_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("t_mem_en", ext_mem_en, 1);
            check("t_no_err", bus_err, 0);
            tick;
        end
        check("t_dm_rvalid", dm_rvalid, 1);
        check("t_bus_err", bus_err, 1);
        check("t_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        check("t_mem_en_off", ext_mem_en, 0);
        tick;
        check("t_err_pulse", bus_err, 0);
        check("t_idle", ext_mem_en, 0);
        // ready on exactly the 16th access cycle still succeeds
        ext_data_in = 32'h1234_5678;
        dm_req = 1'b1;
        tick;
        dm_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("t2_mem_en", ext_mem_en, 1);
            if (i == 15) ext_ready = 1'b1;
            tick;
        end
        check("t2_dm_rvalid", dm_rvalid, 1);
        check("t2_bus_err", bus_err, 0);
        check("t2_dm_rdata", dm_rdata, 32'h1234_5678);
`else
        // without the timeout an access waits as long as ext_ready stays low
        ext_ready = 1'b0; ext_data_in = 32'h1234_5678;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        tick;
        dm_req = 1'b0;
        for (int i = 0; i < 24; i++) begin
            check("w_mem_en", ext_mem_en, 1);
            check("w_no_err", bus_err, 0);
            check("w_no_rvalid", dm_rvalid, 0);
            if (i == 23) ext_ready = 1'b1;
            tick;
        end
        check("w_dm_rvalid", dm_rvalid, 1);
        check("w_bus_err", bus_err, 0);
        check("w_dm_rdata", dm_rdata, 32'h1234_5678);
`endif
        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ext_mem_arbiter.md
Name: ext_mem_arbiter

Overview:
- Sits directly downstream of the processor core and owns the single external memory port (ext_addr / ext_data_out / ext_data_in / ext_mem_en).
- Arbitrates between the instruction-fetch requester and the data load/store requester.
- Runs one external transaction at a time with a ready-based wait-state handshake.
- Returns read data or write acknowledgement to the owning requester.

Parameters:
- FETCH_STARVE_LIMIT, 2: consecutive data grants allowed while a fetch is pending; at the limit, fetch wins the next grant.
- TIMEOUT_CYCLES, 16: ACCESS cycles without ext_ready before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted (combinational, IDLE only)
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched instruction word
- dm_req  in  1  data request; held with dm_* until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  4  byte enables for stores
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_gnt  out  1  data request accepted (combinational, IDLE only)
- dm_rvalid  out  1  one-cycle pulse: load data valid or store complete
- dm_rdata  out  32  load data
- ext_addr  out  32  word-aligned external address
- ext_data_out  out  32  external write data
- ext_data_in  in  32  external read data
- ext_mem_en  out  1  external access active
- ext_we  out  1  external write strobe
- ext_be  out  4  external byte enables
- ext_ready  in  1  external access completes this cycle
- bus_err  out  1  one-cycle pulse on aborted access

Behaviour:
- FSM states: IDLE, ACCESS.
- Reset (reset == 0 at a clk edge):
  - State goes to IDLE and the starvation counter clears.
  - All outputs are 0: gnt, rvalid, rdata, ext_*, bus_err.
  - Reset mid-ACCESS drops ext_mem_en on the next edge; no rvalid is issued for the killed transaction.
- Grant in IDLE:
  - Data has priority.
  - Exception: if_req is pending and data_streak == FETCH_STARVE_LIMIT, then fetch is granted.
  - Exactly one gnt is high in a cycle; never both.
  - On the grant edge: latch owner, address, we, be and wdata; state goes to ACCESS.
  - data_streak increments on a data grant made while if_req = 1, saturating at the limit. It clears on any fetch grant.
- ACCESS:
  - ext_mem_en = 1.
  - ext_addr = {latched_addr[31:2], 2'b00}.
  - ext_we / ext_be / ext_data_out come from the latched values.
  - For a fetch owner: ext_we = 0 and ext_be = 4'hF.
  - All ext_* outputs are registered and stable for the whole access.
  - ext_ready = 1: next edge returns to IDLE, pulses the owner's rvalid and captures ext_data_in into the owner's rdata. Stores pulse dm_rvalid and leave dm_rdata unchanged.
  - ext_ready = 0: stay in ACCESS (wait state), with no limit when the optional feature is absent.
- Latency:
  - Zero wait states: gnt at cycle N, ext_mem_en at N+1, rvalid at N+2.
  - Back-to-back throughput is one transaction per 2 cycles; a new gnt is possible in the same cycle rvalid is high.
- Outputs outside ACCESS: ext_mem_en = 0, ext_we = 0, ext_be = 0. ext_addr and ext_data_out hold their last values.
- rdata holds its value until the next completion for the same owner.

Optional Feature:
- Macro: EXT_MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS.
  - When the count reaches TIMEOUT_CYCLES with ext_ready still 0, the FSM aborts to IDLE.
  - The owner's rvalid pulses with rdata = 32'hDEAD_BEEF (stores: rdata unchanged), and bus_err pulses in the same cycle.
  - ext_ready arriving on exactly the timeout cycle counts as success.
- Undefined: no counter, waits forever, bus_err tied 0.

Decomposition:
- Shared package ext_mem_pkg:
  - typedef enum logic {IDLE, ACCESS} arb_state_t
  - typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t
  - localparam BUS_ERR_DATA = 32'hDEAD_BEEF
  - localparam BE_WORD = 4'hF
- No sub-module needed. Arbitration priority and the streak counter can be factored into one small sub-module, ext_mem_prio, if desired.

Test Plan:
- Fetch only: if_req with if_addr = 0x0000_0102, ext_ready tied 1, ext_data_in = 0x0000_0013 -> ext_addr = 0x0000_0100, ext_be = 0xF, if_rvalid 2 cycles after if_gnt, if_rdata = 0x0000_0013.
- Store with 3 wait states: dm_we = 1, dm_be = 0x3, dm_addr = 0x20, dm_wdata = 0xAABB_CCDD -> ext_mem_en high for 4 cycles, ext_we = 1, ext_be = 0x3, ext_data_out = 0xAABB_CCDD, one dm_rvalid pulse, dm_rdata unchanged.
- Simultaneous requests held continuously (limit 2) -> grant order D, D, F, D, D, F; never both gnts high.
- Reset driven low during a wait-state ACCESS -> all outputs 0 next cycle, no rvalid; after release, a fresh if_req is granted normally.
- With EXT_MEM_ARBITER_TIMEOUT_EN and ext_ready held 0 on a load -> after 16 ACCESS cycles, dm_rvalid = 1, bus_err = 1, dm_rdata = 0xDEAD_BEEF, FSM back in IDLE.
- With EXT_MEM_ARBITER_TIMEOUT_EN and ext_ready = 1 exactly on the 16th ACCESS cycle -> normal completion, bus_err = 0.
